// File: rtl/dmem_responder.sv
// Data-memory responder for the LEGv8 DM_* interface: one request at a time,
// WAIT programmable wait states, one-cycle DM_ready completion pulse.
module dmem_responder #(
   parameter int N     = 64,
   parameter int DEPTH = 32,
   parameter int WAIT  = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] DM_addr,
   input  logic [N-1:0] DM_writeData,
   input  logic         DM_writeEnable,
   input  logic         DM_readEnable,
   output logic [N-1:0] DM_readData,
   output logic         DM_ready,
   output logic         DM_error,
   output logic         DM_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [N-1:0] LIMIT = N'(DEPTH * 8);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [N-1:0]   addr_q, addr_d;
   logic [N-1:0]   wdata_q, wdata_d;
   logic [N-1:0]   rdata_q, rdata_d;
   logic           we_q, we_d;
   logic           re_q, re_d;
   logic [N-1:0]   mem_q [DEPTH];

   logic [AW-1:0]  idx;
   logic           legal;
   logic           mem_we;

   // Legality is judged on the latched request, so DM_error stays stable in RESP.
   assign idx   = addr_q[AW+2:3];
   assign legal = !(we_q && re_q) && (addr_q[2:0] == 3'b000) && (addr_q < LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      re_d    = re_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (DM_readEnable || DM_writeEnable) begin
               addr_d  = DM_addr;
               wdata_d = DM_writeData;
               we_d    = DM_writeEnable;
               re_d    = DM_readEnable;
               cnt_d   = 4'(WAIT);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               mem_we  = legal && we_q;
               if (legal && re_q) begin
                  rdata_d = mem_q[idx];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         rdata_q <= rdata_d;
      end
   end

   // Whole-array clear on reset rules out block RAM; the array is flop-based.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign DM_readData = rdata_q;
   assign DM_ready    = (state_q == RESP);
   assign DM_error    = (state_q == RESP) && !legal;
   assign DM_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, randomized
// transactions against an array model, and a reset-during-BUSY sequence.
module tb_dmem_responder;

   localparam int N      = 64;
   localparam int DEPTH  = 32;
   localparam int WAIT_A = 2;
   localparam int WAIT_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [N-1:0] DM_addr, DM_writeData, DM_readData;
   logic         DM_writeEnable, DM_readEnable, DM_ready, DM_error, DM_busy;

   logic         rst4_n;
   logic [N-1:0] a4, wd4, rd4;
   logic         we4, re4, rdy4, err4, busy4;

   dmem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(WAIT_A)) u_dut (
      .clk(clk), .reset(reset),
      .DM_addr(DM_addr), .DM_writeData(DM_writeData),
      .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
      .DM_readData(DM_readData), .DM_ready(DM_ready),
      .DM_error(DM_error), .DM_busy(DM_busy)
   );

   dmem_responder #(.N(N), .DEPTH(DEPTH), .WAIT(WAIT_B)) u_dut4 (
      .clk(clk), .reset(rst4_n),
      .DM_addr(a4), .DM_writeData(wd4),
      .DM_writeEnable(we4), .DM_readEnable(re4),
      .DM_readData(rd4), .DM_ready(rdy4),
      .DM_error(err4), .DM_busy(busy4)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] model_mem [DEPTH];
   logic [63:0] model_rd;

   typedef struct {
      string       name;
      bit          we;
      bit          re;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] baddr;
      logic [63:0] bdata;
      bit          exp_err;
      logic [63:0] exp_rd;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference behaviour: legal means single op, 8-byte aligned, inside the array.
   task automatic model_apply(input bit we, input bit re, input logic [63:0] addr,
                              input logic [63:0] wd, output bit exp_err,
                              output logic [63:0] exp_rd);
      bit legal;
      legal = !(we && re) && (addr % 8 == 0) && (addr < 64'(DEPTH * 8));
      if (legal && we) model_mem[addr / 8] = wd;
      if (legal && re) model_rd = model_mem[addr / 8];
      exp_err = !legal;
      exp_rd  = model_rd;
   endtask

   // Called on a negedge; returns on a negedge with the DUT back in IDLE.
   task automatic run_txn(input string name, input bit we, input bit re,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] baddr, input logic [63:0] bdata,
                          input bit exp_err, input logic [63:0] exp_rd);
      int lat;
      bit stray;
      logic got_err;
      logic [63:0] got_rd;
      DM_addr = addr; DM_writeData = wd; DM_writeEnable = we; DM_readEnable = re;
      @(posedge clk);
      @(negedge clk);
      chk({name, ".busy_rise"}, 64'(DM_busy), 64'd1);
      DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
      DM_addr = baddr; DM_writeData = bdata;
      lat = 0; stray = 1'b0;
      while (!DM_ready && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (!DM_ready && DM_error) stray = 1'b1;
      end
      got_err = DM_error; got_rd = DM_readData;
      chk({name, ".latency"}, 64'(lat), 64'(WAIT_A + 1));
      chk({name, ".error"}, 64'(got_err), 64'(exp_err));
      chk({name, ".rdata"}, got_rd, exp_rd);
      chk({name, ".err_outside_resp"}, 64'(stray), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({name, ".ready_fall"}, 64'(DM_ready), 64'd0);
      chk({name, ".busy_fall"}, 64'(DM_busy), 64'd0);
      $display("txn %-14s we=%0b re=%0b addr=0x%0h wd=0x%0h -> err=%0b rd=0x%0h lat=%0d",
               name, we, re, addr, wd, got_err, got_rd, lat);
   endtask

   initial begin
      bit          e_err;
      logic [63:0] e_rd;

      reset = 1'b0; rst4_n = 1'b0;
      DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0; DM_readEnable = 1'b1;
      a4 = '0; wd4 = '0; we4 = 1'b0; re4 = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_rd = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.hold_outputs", {DM_readData[59:0], DM_ready, DM_error, DM_busy, 1'b0}, 64'd0);
      DM_readEnable = 1'b0;
      reset = 1'b1; rst4_n = 1'b1;
      @(negedge clk);
      chk("rst.readData", DM_readData, 64'd0);
      chk("rst.ready_error_busy", {61'd0, DM_ready, DM_error, DM_busy}, 64'd0);

      vecs[0]  = '{"rd_zero",    0, 1, 64'h0,  64'h0,                 64'h18, 64'hFFFF, 0, 64'h0};
      vecs[1]  = '{"wr_18",      1, 0, 64'h18, 64'hDEADBEEFCAFEF00D,  64'h18, 64'hFFFF, 0, 64'h0};
      vecs[2]  = '{"rd_18",      0, 1, 64'h18, 64'h0,                 64'h18, 64'hFFFF, 0, 64'hDEADBEEFCAFEF00D};
      vecs[3]  = '{"wr_misalign",1, 0, 64'h1C, 64'h11,                64'h18, 64'hFFFF, 1, 64'hDEADBEEFCAFEF00D};
      vecs[4]  = '{"rd_18_again",0, 1, 64'h18, 64'h0,                 64'h18, 64'hFFFF, 0, 64'hDEADBEEFCAFEF00D};
      vecs[5]  = '{"rd_oor_100", 0, 1, 64'h100,64'h0,                 64'h18, 64'hFFFF, 1, 64'hDEADBEEFCAFEF00D};
      vecs[6]  = '{"both_en_8",  1, 1, 64'h8,  64'h55,                64'h18, 64'hFFFF, 1, 64'hDEADBEEFCAFEF00D};
      vecs[7]  = '{"rd_8",       0, 1, 64'h8,  64'h0,                 64'h18, 64'hFFFF, 0, 64'h0};
      vecs[8]  = '{"wr_10_scram",1, 0, 64'h10, 64'h1234,              64'h20, 64'h9999, 0, 64'h0};
      vecs[9]  = '{"rd_10",      0, 1, 64'h10, 64'h0,                 64'h18, 64'hFFFF, 0, 64'h1234};
      vecs[10] = '{"rd_20",      0, 1, 64'h20, 64'h0,                 64'h18, 64'hFFFF, 0, 64'h0};
      vecs[11] = '{"wr_last",    1, 0, 64'hF8, 64'hA5A5,              64'h18, 64'hFFFF, 0, 64'h0};
      vecs[12] = '{"rd_last",    0, 1, 64'hF8, 64'h0,                 64'h18, 64'hFFFF, 0, 64'hA5A5};
      vecs[13] = '{"rd_high_bit",0, 1, 64'h0001000000000018, 64'h0,   64'h18, 64'hFFFF, 1, 64'hA5A5};
      vecs[14] = '{"rd_misal_ff",0, 1, 64'hFF, 64'h0,                 64'h18, 64'hFFFF, 1, 64'hA5A5};

      for (int v = 0; v < 15; v++) begin
         model_apply(vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].wdata, e_err, e_rd);
         run_txn(vecs[v].name, vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].wdata,
                 vecs[v].baddr, vecs[v].bdata, vecs[v].exp_err, vecs[v].exp_rd);
      end

      for (int t = 0; t < 60; t++) begin
         bit          we, re;
         logic [63:0] addr, wd;
         int          sel;
         sel = $urandom_range(0, 7);
         we  = (sel == 0) || (sel <= 3);
         re  = (sel == 0) || (sel >= 4);
         case ($urandom_range(0, 9))
            0:       addr = 64'($urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7));
            1:       addr = 64'(DEPTH * 8) + 64'($urandom_range(0, 63) * 8);
            2:       addr = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFF8;
            default: addr = 64'($urandom_range(0, DEPTH - 1) * 8);
         endcase
         wd = {$urandom, $urandom};
         model_apply(we, re, addr, wd, e_err, e_rd);
         run_txn($sformatf("rand%0d", t), we, re, addr, wd,
                 64'($urandom_range(0, DEPTH - 1) * 8), {$urandom, $urandom}, e_err, e_rd);
      end

      // WAIT=4 instance: reset lands two cycles into BUSY on a write to 0x0.
      begin
         int  lat;
         bit  saw_ready;
         a4 = 64'h0; wd4 = 64'hCAFE_0000_0000_BEEF; we4 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         we4 = 1'b0;
         chk("rst_mid.busy_rise", 64'(busy4), 64'd1);
         @(posedge clk);
         @(posedge clk);
         #2 rst4_n = 1'b0;
         #1 chk("rst_mid.busy_drop", 64'(busy4), 64'd0);
         saw_ready = 1'b0;
         repeat (2) begin
            @(negedge clk);
            if (rdy4) saw_ready = 1'b1;
         end
         rst4_n = 1'b1;
         repeat (10) begin
            @(negedge clk);
            if (rdy4) saw_ready = 1'b1;
         end
         chk("rst_mid.no_ready", 64'(saw_ready), 64'd0);
         a4 = 64'h0; re4 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         re4 = 1'b0;
         lat = 0;
         while (!rdy4 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
         end
         chk("rst_mid.read_latency", 64'(lat), 64'(WAIT_B + 1));
         chk("rst_mid.read_word0", rd4, 64'h0);
         chk("rst_mid.read_error", 64'(err4), 64'd0);
         $display("txn %-14s read 0x0 after reset -> err=%0b rd=0x%0h lat=%0d",
                  "rst_mid_read", err4, rd4, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
